// File: rtl/cfg_serial_loader.sv
// Serial configuration loader: shifts a captured parallel image into a latched
// shift-register chain, optionally reads it back for verification, then latches it.
module cfg_serial_loader #(
    parameter int unsigned CHAIN_LEN = 104,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          VERIFY_EN = 1'b1,
    parameter int unsigned ERRW      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] IMAGE,
    input  logic                 MISO,
    output logic                 SEL,
    output logic                 MOSI,
    output logic                 SHIFT_EN,
    output logic                 LATCH,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [ERRW-1:0]      ERR_CNT
);

    localparam int unsigned IdxW = $clog2(CHAIN_LEN);
    localparam int unsigned DivW = $clog2(CLK_DIV);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(CHAIN_LEN - 1);
    localparam logic [DivW-1:0] LastDiv = DivW'(CLK_DIV - 1);
    localparam logic [ERRW-1:0] ErrSat  = ERRW'(CHAIN_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StVerify,
        StLatch,
        StFin
    } state_e;

    state_e                state_q, state_d;
    logic [CHAIN_LEN-1:0]  shadow_q, shadow_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DivW-1:0]       div_q, div_d;
    logic                  err_q, err_d;
    logic [ERRW-1:0]       err_cnt_q, err_cnt_d;

    logic            in_shift;
    logic            strobe;
    logic [IdxW-1:0] bit_pos;
    logic            cur_bit;

    // Decode outputs from the current state; the bit index maps to an image position
    // according to the shift order, so both passes present bits in the same order.
    always_comb begin
        in_shift = (state_q == StLoad) || (state_q == StVerify);
        strobe   = in_shift && (div_q == LastDiv);
        bit_pos  = MSB_FIRST ? (LastIdx - idx_q) : idx_q;
        cur_bit  = shadow_q[bit_pos];
        SEL      = in_shift;
        MOSI     = in_shift & cur_bit;
        SHIFT_EN = strobe;
        LATCH    = (state_q == StLatch);
        DONE     = (state_q == StFin);
        BUSY     = (state_q != StIdle);
        ERR      = err_q;
        ERR_CNT  = err_cnt_q;
    end

    // Next-state logic; ABORT overrides everything and freezes the error bookkeeping.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        div_d     = div_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (ABORT && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        shadow_d  = IMAGE;
                        err_d     = 1'b0;
                        err_cnt_d = '0;
                        idx_d     = '0;
                        div_d     = '0;
                        state_d   = StLoad;
                    end
                end
                StLoad, StVerify: begin
                    if (strobe) begin
                        div_d = '0;
                        // Chain output is sampled before it shifts on this strobe.
                        if ((state_q == StVerify) && (MISO != cur_bit) && (err_cnt_q != ErrSat)) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (idx_q == LastIdx) begin
                            idx_d = '0;
                            if (state_q == StLoad) begin
                                state_d = VERIFY_EN ? StVerify : StLatch;
                            end else begin
                                err_d   = (err_cnt_d != '0);
                                state_d = StLatch;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                StLatch: state_d = StFin;
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Bench for cfg_serial_loader: three 8-bit instances (MSB-first, LSB-first,
// MSB-first with verify) share stimulus; the verify instance drives a chain model.
module tb_cfg_serial_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] image;

    logic [2:0] sel_w, mosi_w, shift_w, latch_w, busy_w, done_w, err_w;
    logic [3:0] cnt_w [3];

    // Behavioural 8-bit chain: shifts in at bit 0, serial output is bit 7.
    logic [7:0] chain_q;
    int         nshift;
    logic       chain_clr;
    logic       stuck;
    logic       miso;

    int n_vec  = 0;
    int n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cfg_serial_loader #(.CHAIN_LEN(8), .CLK_DIV(2), .MSB_FIRST(1'b1), .VERIFY_EN(1'b0)) u_msb (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .IMAGE(image), .MISO(1'b0),
        .SEL(sel_w[0]), .MOSI(mosi_w[0]), .SHIFT_EN(shift_w[0]), .LATCH(latch_w[0]),
        .BUSY(busy_w[0]), .DONE(done_w[0]), .ERR(err_w[0]), .ERR_CNT(cnt_w[0])
    );

    cfg_serial_loader #(.CHAIN_LEN(8), .CLK_DIV(2), .MSB_FIRST(1'b0), .VERIFY_EN(1'b0)) u_lsb (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .IMAGE(image), .MISO(1'b0),
        .SEL(sel_w[1]), .MOSI(mosi_w[1]), .SHIFT_EN(shift_w[1]), .LATCH(latch_w[1]),
        .BUSY(busy_w[1]), .DONE(done_w[1]), .ERR(err_w[1]), .ERR_CNT(cnt_w[1])
    );

    cfg_serial_loader #(.CHAIN_LEN(8), .CLK_DIV(2), .MSB_FIRST(1'b1), .VERIFY_EN(1'b1)) u_ver (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .IMAGE(image), .MISO(miso),
        .SEL(sel_w[2]), .MOSI(mosi_w[2]), .SHIFT_EN(shift_w[2]), .LATCH(latch_w[2]),
        .BUSY(busy_w[2]), .DONE(done_w[2]), .ERR(err_w[2]), .ERR_CNT(cnt_w[2])
    );

    // Faulty variant: the cell at bit 2 loses its value each time a full image has
    // settled, so exactly image bit 2 reads back as 0.
    always @(posedge clk) begin
        if (chain_clr) begin
            chain_q <= 8'h00;
            nshift  <= 0;
        end else if (shift_w[2]) begin
            if (stuck && (nshift % 8 == 7)) chain_q <= {chain_q[6:0], mosi_w[2]} & 8'hFB;
            else                            chain_q <= {chain_q[6:0], mosi_w[2]};
            nshift <= nshift + 1;
        end
    end
    assign miso = chain_q[7];

    typedef struct {
        int         unit;
        logic [7:0] image;
        logic       stuck;
        logic       clr;
        int         restart_t;   // cycle (from first BUSY cycle) to re-pulse START, 0 = none
        logic [7:0] restart_img;
        logic [7:0] exp_seq;     // MOSI on LOAD strobes, first strobe in bit 7
        int         exp_latch;   // cycle of LATCH, first BUSY cycle = 1
        logic       exp_err;
        logic [3:0] exp_cnt;
        logic       chk_chain;
        logic [7:0] exp_chain;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy_w != 3'b000 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("idle before start", {29'd0, busy_w}, 32'd0);
    endtask

    task automatic run_vec(input int v);
        vec_t       r;
        int         u, t, ns, bad, t_latch, t_done, n_latch, n_done;
        logic [7:0] seq;
        logic       sel_at_latch, busy_after, first_ok;
        r = tbl[v];
        u = r.unit;
        wait_idle();
        stuck = r.stuck;
        if (r.clr) begin
            chain_clr = 1'b1;
            @(negedge clk);
            chain_clr = 1'b0;
        end
        @(negedge clk);
        image = r.image;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1; ns = 0; bad = 0; seq = 8'h00;
        t_latch = -1; t_done = -1; n_latch = 0; n_done = 0;
        sel_at_latch = 1'b1; busy_after = 1'b1; first_ok = 1'b0;
        while (t <= r.exp_latch + 3) begin
            start = (r.restart_t != 0) && (t == r.restart_t);
            if (start) image = r.restart_img;
            if (t == 1) first_ok = busy_w[u] && sel_w[u] && (mosi_w[u] == r.exp_seq[7]);
            if (shift_w[u]) begin
                if (ns < 8) seq[7-ns] = mosi_w[u];
                if (t != 2 * (ns + 1)) bad++;
                ns++;
            end
            if (latch_w[u]) begin
                n_latch++;
                if (t_latch < 0) begin
                    t_latch      = t;
                    sel_at_latch = sel_w[u];
                end
            end
            if (done_w[u]) begin
                n_done++;
                if (t_done < 0) t_done = t;
            end
            if (t == r.exp_latch + 2) busy_after = busy_w[u];
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check($sformatf("v%0d first cycle busy/sel/mosi", v), {31'd0, first_ok}, 32'd1);
        check($sformatf("v%0d mosi sequence", v), {24'd0, seq}, {24'd0, r.exp_seq});
        check($sformatf("v%0d strobe count", v), ns, (r.exp_latch - 1) / 2);
        check($sformatf("v%0d strobe spacing errors", v), bad, 0);
        check($sformatf("v%0d latch cycle", v), t_latch, r.exp_latch);
        check($sformatf("v%0d latch pulses", v), n_latch, 1);
        check($sformatf("v%0d sel during latch", v), {31'd0, sel_at_latch}, 32'd0);
        check($sformatf("v%0d done cycle", v), t_done, r.exp_latch + 1);
        check($sformatf("v%0d done pulses", v), n_done, 1);
        check($sformatf("v%0d busy after done", v), {31'd0, busy_after}, 32'd0);
        check($sformatf("v%0d err", v), {31'd0, err_w[u]}, {31'd0, r.exp_err});
        check($sformatf("v%0d err_cnt", v), {28'd0, cnt_w[u]}, {28'd0, r.exp_cnt});
        if (r.chk_chain) check($sformatf("v%0d chain contents", v), {24'd0, chain_q}, {24'd0, r.exp_chain});
    endtask

    initial begin
        int ns, pulses;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 0, 8'h00, 8'hA5, 17, 1'b0, 4'd0, 1'b0, 8'h00};
        tbl[1] = '{1, 8'h01, 1'b0, 1'b0, 0, 8'h00, 8'h80, 17, 1'b0, 4'd0, 1'b0, 8'h00};
        tbl[2] = '{2, 8'h3C, 1'b0, 1'b1, 0, 8'h00, 8'h3C, 33, 1'b0, 4'd0, 1'b1, 8'h3C};
        tbl[3] = '{2, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 8'h3C, 33, 1'b0, 4'd0, 1'b1, 8'h3C};
        tbl[4] = '{2, 8'hFF, 1'b1, 1'b1, 0, 8'h00, 8'hFF, 33, 1'b1, 4'd1, 1'b0, 8'h00};
        tbl[5] = '{0, 8'hA5, 1'b0, 1'b0, 5, 8'h5A, 8'hA5, 17, 1'b0, 4'd0, 1'b0, 8'h00};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; image = 8'h00;
        chain_clr = 1'b1; stuck = 1'b0;
        repeat (2) @(negedge clk);
        chain_clr = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset outputs u%0d", u),
                  {20'd0, sel_w[u], mosi_w[u], shift_w[u], latch_w[u], busy_w[u], done_w[u],
                   err_w[u], cnt_w[u], 1'b0}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) run_vec(v);

        // ABORT on the third LOAD strobe.
        wait_idle();
        @(negedge clk);
        image = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ns = 0;
        for (int i = 0; i < 40 && ns < 3; i++) begin
            if (shift_w[0]) ns++;
            if (ns < 3) @(negedge clk);
        end
        check("abort reached third strobe", ns, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy/sel/shift", {29'd0, busy_w[0], sel_w[0], shift_w[0]}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (latch_w != 3'b000 || done_w != 3'b000) pulses++;
            @(negedge clk);
        end
        check("abort no latch/done", pulses, 0);
        run_vec(0);

        // Reset mid-VERIFY with a partial error count.
        wait_idle();
        stuck = 1'b1;
        chain_clr = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
        image = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid-verify partial err_cnt", {28'd0, cnt_w[2]}, 32'd1);
        check("mid-verify strobe active", {31'd0, shift_w[2] & busy_w[2]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {21'd0, sel_w[2], mosi_w[2], shift_w[2], latch_w[2], busy_w[2], done_w[2],
               err_w[2], cnt_w[2]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // START and ABORT together in IDLE: START wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort in idle", {30'd0, busy_w[0], sel_w[0]}, 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort returns all idle", {29'd0, busy_w}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
